// File: rtl/csa_tree_pipe.sv
// Pipelined Wallace-tree (3:2 CSA) multi-operand adder with an optional
// accumulation group per result and a single global stall.
module csa_tree_pipe #(
  parameter int NBITS     = 16,
  parameter int NOPS      = 9,
  parameter int REG_EVERY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NOPS*NBITS-1:0] in_ops,
  input  logic                  in_acc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBITS-1:0]      out_sum,
  output logic [15:0]           out_beats
);

  function automatic int rows_at(input int layer);
    int n;
    n = NOPS;
    for (int i = 0; i < layer; i++) if (n > 2) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int layer_count();
    int n;
    int l;
    n = NOPS;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  function automatic logic signed [NBITS-1:0] csa_carry(
    input logic signed [NBITS-1:0] a, b, c);
    logic signed [NBITS-1:0] m;
    m = (a & b) | (a & c) | (b & c);
    return m <<< 1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  localparam int NLAYERS = layer_count();
  localparam int LT      = NLAYERS - 1;

  logic en;
  logic vld_p2;

  assign en        = !vld_p2 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  for (genvar i = 0; i < NLAYERS; i++) begin : g_lyr
    localparam int NI = rows_at(i);
    localparam int NO = rows_at(i + 1);
    localparam int NT = NI / 3;

    logic signed [NBITS-1:0] rin  [NI];
    logic signed [NBITS-1:0] rout [NO];
    logic vld, acc, last;

    if (i == 0) begin : g_src
      always_comb begin
        for (int k = 0; k < NI; k++) rin[k] = $signed(in_ops[k*NBITS +: NBITS]);
      end
      assign vld  = in_valid;
      assign acc  = in_acc;
      assign last = in_last;
    end else if (i % REG_EVERY == 0) begin : g_reg
      // ---- tree stage boundary: registered every REG_EVERY layers ----
      always_ff @(posedge clock) begin
        if (en) rin <= g_lyr[i-1].rout;
      end
      always_ff @(posedge clock) begin
        if (reset) begin
          vld  <= 1'b0;
          acc  <= 1'b0;
          last <= 1'b0;
        end else if (en) begin
          vld  <= g_lyr[i-1].vld;
          acc  <= g_lyr[i-1].acc;
          last <= g_lyr[i-1].last;
        end
      end
    end else begin : g_thru
      assign rin  = g_lyr[i-1].rout;
      assign vld  = g_lyr[i-1].vld;
      assign acc  = g_lyr[i-1].acc;
      assign last = g_lyr[i-1].last;
    end

    // Full triples compress to sum/carry; leftover rows pass straight down.
    always_comb begin
      for (int k = 0; k < NO; k++) rout[k] = '0;
      for (int t = 0; t < NT; t++) begin
        rout[2*t]   = rin[3*t] ^ rin[3*t+1] ^ rin[3*t+2];
        rout[2*t+1] = csa_carry(rin[3*t], rin[3*t+1], rin[3*t+2]);
      end
      for (int k = 0; k < NI - 3 * NT; k++) rout[2*NT+k] = rin[3*NT+k];
    end
  end

  // ---- final tree stage boundary: two redundant rows ----
  logic signed [NBITS-1:0] tree_a_p1, tree_b_p1;
  logic                    vld_p1, acc_p1, last_p1;

  always_ff @(posedge clock) begin
    if (en) begin
      tree_a_p1 <= g_lyr[LT].rout[0];
      tree_b_p1 <= g_lyr[LT].rout[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      acc_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= g_lyr[LT].vld;
      acc_p1  <= g_lyr[LT].acc;
      last_p1 <= g_lyr[LT].last;
    end
  end

  // ---- output stage boundary: carry-propagate add plus accumulator ----
  logic signed [NBITS-1:0] tree_sum;
  logic signed [NBITS-1:0] accum_p2, sum_p2;
  logic [15:0]             beat_cnt_p2, beats_p2;

  assign tree_sum = tree_a_p1 + tree_b_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2      <= 1'b0;
      accum_p2    <= '0;
      beat_cnt_p2 <= '0;
      sum_p2      <= '0;
      beats_p2    <= '0;
    end else if (en) begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        if (!acc_p1) begin
          // A standalone beat leaves any open group untouched.
          sum_p2   <= tree_sum;
          beats_p2 <= 16'd1;
          vld_p2   <= 1'b1;
        end else if (!last_p1) begin
          accum_p2    <= accum_p2 + tree_sum;
          beat_cnt_p2 <= sat_inc(beat_cnt_p2);
        end else begin
          sum_p2      <= accum_p2 + tree_sum;
          beats_p2    <= sat_inc(beat_cnt_p2);
          vld_p2      <= 1'b1;
          accum_p2    <= '0;
          beat_cnt_p2 <= '0;
        end
      end
    end
  end

  assign out_sum   = sum_p2;
  assign out_beats = beats_p2;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe: a reference model of tree sum and
// accumulation groups queues expected results as beats are accepted.
module tb_csa_tree_pipe;
  localparam int NBITS = 16;
  localparam int NOPS  = 9;
  localparam int OW    = NBITS * NOPS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_acc = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [OW-1:0] in_ops = '0;
  logic          in_ready, out_valid;
  logic [NBITS-1:0] out_sum;
  logic [15:0]   out_beats;

  csa_tree_pipe #(.NBITS(NBITS), .NOPS(NOPS), .REG_EVERY(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(in_ops), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] beats;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] log_sum[$];
  logic [15:0] log_beats[$];
  logic [15:0] m_acc = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] ts;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [OW-1:0] ops_fill(input logic [15:0] v);
    logic [OW-1:0] r;
    for (int k = 0; k < NOPS; k++) r[k*NBITS +: NBITS] = v;
    return r;
  endfunction

  function automatic logic [OW-1:0] ops_seq();
    logic [OW-1:0] r;
    for (int k = 0; k < NOPS; k++) r[k*NBITS +: NBITS] = 16'(k + 1);
    return r;
  endfunction

  function automatic logic [OW-1:0] ops_rand();
    logic [OW-1:0] r;
    for (int k = 0; k < NOPS; k++) r[k*NBITS +: NBITS] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [15:0] model_sum(input logic [OW-1:0] ops);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < NOPS; k++) s = s + ops[k*NBITS +: NBITS];
    return s;
  endfunction

  // Scoreboard: compare outputs, then model newly accepted beats.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_acc = '0;
      m_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("out_sum", {16'd0, out_sum}, {16'd0, e.sum});
          check("out_beats", {16'd0, out_beats}, {16'd0, e.beats});
        end
        log_sum.push_back(out_sum);
        log_beats.push_back(out_beats);
      end
      if (in_valid && in_ready) begin
        ts = model_sum(in_ops);
        if (!in_acc) exp_q.push_back('{sum: ts, beats: 16'd1});
        else if (!in_last) begin
          m_acc = m_acc + ts;
          m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        end else begin
          exp_q.push_back('{sum: m_acc + ts, beats: (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1});
          m_acc = '0;
          m_cnt = '0;
        end
      end
    end
  end

  task automatic send(input logic [OW-1:0] ops, input logic acc, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_ops   = ops;
    in_acc   = acc;
    in_last  = last;
    @(negedge clock);
    while (!in_ready && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(posedge clock);
      g++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic clear_log();
    log_sum.delete();
    log_beats.delete();
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_beats", {16'd0, out_beats}, 32'd0);
    @(posedge clock);
    #1;

    // Single beat with latency measurement
    clear_log();
    send(ops_seq(), 1'b0, 1'b0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, 32'd3);
    drain();
    check("single_count", log_sum.size(), 32'd1);
    if (log_sum.size() >= 1) begin
      check("single_sum", {16'd0, log_sum[0]}, 32'd45);
      check("single_beats", {16'd0, log_beats[0]}, 32'd1);
    end

    // Modular wrap
    clear_log();
    send(ops_fill(16'hFFFF), 1'b0, 1'b0);
    drain();
    if (log_sum.size() >= 1) check("wrap_sum", {16'd0, log_sum[0]}, 32'hFFF7);

    // Three-beat accumulation group
    clear_log();
    send(ops_fill(16'd1), 1'b1, 1'b0);
    send(ops_fill(16'd1), 1'b1, 1'b0);
    send(ops_fill(16'd1), 1'b1, 1'b1);
    drain();
    check("acc_count", log_sum.size(), 32'd1);
    if (log_sum.size() >= 1) begin
      check("acc_sum", {16'd0, log_sum[0]}, 32'd27);
      check("acc_beats", {16'd0, log_beats[0]}, 32'd3);
    end

    // Backpressure mid-stream
    clear_log();
    fork
      begin
        for (int b = 0; b < 6; b++) send(ops_rand(), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", log_sum.size(), 32'd6);

    // Reset while a group is open
    send(ops_fill(16'd1), 1'b1, 1'b0);
    send(ops_fill(16'd1), 1'b1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
    send(ops_fill(16'd2), 1'b1, 1'b1);
    drain();
    check("rstgrp_count", log_sum.size(), 32'd1);
    if (log_sum.size() >= 1) begin
      check("rstgrp_sum", {16'd0, log_sum[0]}, 32'd18);
      check("rstgrp_beats", {16'd0, log_beats[0]}, 32'd1);
    end

    // Standalone beat inside an open group
    clear_log();
    send(ops_fill(16'd1), 1'b1, 1'b0);
    send(ops_fill(16'd3), 1'b0, 1'b0);
    send(ops_fill(16'd1), 1'b1, 1'b1);
    drain();
    check("intlv_count", log_sum.size(), 32'd2);
    if (log_sum.size() >= 2) begin
      check("intlv_sum0", {16'd0, log_sum[0]}, 32'd27);
      check("intlv_beats0", {16'd0, log_beats[0]}, 32'd1);
      check("intlv_sum1", {16'd0, log_sum[1]}, 32'd18);
      check("intlv_beats1", {16'd0, log_beats[1]}, 32'd2);
    end

    // Random mix with random output backpressure
    fork
      begin
        for (int b = 0; b < 30; b++)
          send(ops_rand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        send(ops_rand(), 1'b1, 1'b1);
      end
      begin
        repeat (80) begin
          @(posedge clock);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
